lb_seq_player: RTL and testbench

//  Hardware local-bus sequencer upstream of cryomodule: replays a stored list of (addr,data) writes onto lb_*.

---
 rtl/lb_seq_pkg.sv | 16 +
 rtl/lb_read_align.sv | 42 ++++
 rtl/lb_seq_player.sv | 195 +++++++++++++++++++
 tb/tb_lb_seq_player.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lb_seq_pkg.sv
// Shared types and constants for the local-bus sequence player.
package lb_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WRITE,
        STALL,
        READ,
        DRAIN,
        DONE
    } state_t;

    localparam int STALL_ADDR_DEFAULT = 555;

endpackage

// File: rtl/lb_read_align.sv
// Delays the {valid,index,last} tag of each lb_read so it lines up with lb_out.
module lb_read_align #(
    parameter int LEN_W     = 11,
    parameter int READ_PIPE = 2
) (
    input  logic             lb_clk,
    input  logic             lb_rst_n,
    input  logic             in_valid,
    input  logic [LEN_W-1:0] in_index,
    input  logic             in_last,
    output logic             out_valid,
    output logic [LEN_W-1:0] out_index,
    output logic             out_last
);

    typedef struct packed {
        logic             valid;
        logic [LEN_W-1:0] index;
        logic             last;
    } beat_t;

    beat_t pipe [READ_PIPE];

    always_ff @(posedge lb_clk or negedge lb_rst_n) begin
        if (!lb_rst_n) begin
            // NOTE: every stage is reset, not just the valid bit, so beats in flight at reset can never emerge afterwards.
            for (int i = 0; i < READ_PIPE; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= '{valid: in_valid, index: in_index, last: in_last};
            for (int i = 1; i < READ_PIPE; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign out_valid = pipe[READ_PIPE-1].valid;
    assign out_index = pipe[READ_PIPE-1].index;
    assign out_last  = pipe[READ_PIPE-1].last;

endmodule

// File: rtl/lb_seq_player.sv
// Replays a stored (addr,data) write list onto the local bus, then bursts a
// block of reads and streams the returned words out as an indexed sequence.
module lb_seq_player
    import lb_seq_pkg::*;
#(
    parameter int AW         = 17,
    parameter int DW         = 32,
    parameter int PROG_AW    = 8,
    parameter int LEN_W      = 11,
    parameter int SPACING    = 3,
    parameter int READ_PIPE  = 2,
    parameter int STALL_ADDR = STALL_ADDR_DEFAULT
) (
    input  logic               lb_clk,
    input  logic               lb_rst_n,
    input  logic               start,
    input  logic [AW-1:0]      rd_base,
    input  logic [LEN_W-1:0]   rd_len,
    output logic [PROG_AW-1:0] prog_addr,
    input  logic               prog_valid,
    input  logic [AW-1:0]      prog_ca,
    input  logic [DW-1:0]      prog_cd,
    output logic [AW-1:0]      lb_addr,
    output logic [DW-1:0]      lb_data,
    output logic               lb_write,
    output logic               lb_read,
    input  logic [DW-1:0]      lb_out,
    output logic [DW-1:0]      rd_data,
    output logic               rd_valid,
    output logic [LEN_W-1:0]   rd_index,
    output logic               rd_last,
    output logic               busy,
    output logic               done
);

    // Cycles left in a slot after the fetch and decode cycles, minus one.
    localparam logic [DW-1:0] TAIL_LOAD = (SPACING > 2) ? DW'(SPACING - 3) : '0;

    state_t             state, state_d;
    logic               fetch_ph, fetch_ph_d;
    logic [DW-1:0]      cnt, cnt_d;
    logic [PROG_AW-1:0] ptr, ptr_d;
    logic               mem_end, mem_end_d;
    logic               ending, ending_d;
    logic [AW-1:0]      base_q, base_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   idx, idx_d;
    logic               go_tail, tail_done;
    logic               idx_last;
    logic               al_valid, al_last;
    logic [LEN_W-1:0]   al_index;

    assign idx_last = (idx == len_q - LEN_W'(1));

    always_ff @(posedge lb_clk or negedge lb_rst_n) begin
        if (!lb_rst_n) begin
            state    <= IDLE;
            fetch_ph <= 1'b0;
            cnt      <= '0;
            ptr      <= '0;
            mem_end  <= 1'b0;
            ending   <= 1'b0;
            base_q   <= '0;
            len_q    <= '0;
            idx      <= '0;
        end else begin
            // NOTE: state registers use <= so every flop samples the pre-edge values of its peers.
            state    <= state_d;
            fetch_ph <= fetch_ph_d;
            cnt      <= cnt_d;
            ptr      <= ptr_d;
            mem_end  <= mem_end_d;
            ending   <= ending_d;
            base_q   <= base_d;
            len_q    <= len_d;
            idx      <= idx_d;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
        state_d    = state;
        fetch_ph_d = fetch_ph;
        cnt_d      = cnt;
        ptr_d      = ptr;
        mem_end_d  = mem_end;
        ending_d   = ending;
        base_d     = base_q;
        len_d      = len_q;
        idx_d      = idx;
        go_tail    = 1'b0;
        tail_done  = 1'b0;
        lb_write   = 1'b0;
        lb_read    = 1'b0;
        lb_addr    = '0;
        lb_data    = '0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    state_d    = FETCH;
                    fetch_ph_d = 1'b0;
                    ptr_d      = '0;
                    mem_end_d  = 1'b0;
                    ending_d   = 1'b0;
                    base_d     = rd_base;
                    len_d      = rd_len;
                    idx_d      = '0;
                end
            end
            // Phase 0 presents prog_addr; phase 1 sees the RAM word and decodes it.
            FETCH: begin
                fetch_ph_d = ~fetch_ph;
                if (fetch_ph) begin
                    if (!prog_valid || mem_end) begin
                        ending_d = 1'b1;
                        go_tail  = 1'b1;
                    end else begin
                        if (ptr == '1) mem_end_d = 1'b1;
                        else           ptr_d     = ptr + PROG_AW'(1);
                        if (prog_ca == AW'(STALL_ADDR)) begin
                            if (prog_cd != '0) begin
                                state_d = STALL;
                                cnt_d   = prog_cd - DW'(1);
                            end else begin
                                go_tail = 1'b1;
                            end
                        end else begin
                            lb_write = 1'b1;
                            lb_addr  = prog_ca;
                            lb_data  = prog_cd;
                            go_tail  = 1'b1;
                        end
                    end
                end
            end
            STALL: begin
                if (cnt == '0) go_tail = 1'b1;
                else           cnt_d   = cnt - DW'(1);
            end
            // WRITE is the fixed slot tail shared by writes, stalls and the end slot.
            WRITE: begin
                if (cnt == '0) tail_done = 1'b1;
                else           cnt_d     = cnt - DW'(1);
            end
            READ: begin
                lb_read = 1'b1;
                lb_addr = base_q + AW'(idx);
                if (idx_last) state_d = DRAIN;
                else          idx_d   = idx + LEN_W'(1);
            end
            DRAIN: begin
                if (al_valid && al_last) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (go_tail && SPACING > 2) begin
            state_d = WRITE;
            cnt_d   = TAIL_LOAD;
        end else if (go_tail || tail_done) begin
            if (!ending_d)         state_d = FETCH;
            else if (len_q != '0)  state_d = READ;
            else                   state_d = DONE;
        end
    end

    lb_read_align #(
        .LEN_W     (LEN_W),
        .READ_PIPE (READ_PIPE)
    ) u_align (
        .lb_clk    (lb_clk),
        .lb_rst_n  (lb_rst_n),
        .in_valid  (lb_read),
        .in_index  (lb_read ? idx : '0),
        .in_last   (lb_read && idx_last),
        .out_valid (al_valid),
        .out_index (al_index),
        .out_last  (al_last)
    );

    assign prog_addr = ptr;
    assign rd_valid  = al_valid;
    assign rd_index  = al_index;
    assign rd_last   = al_last;
    assign rd_data   = al_valid ? lb_out : '0;
    assign busy      = (state != IDLE) && (state != DONE);
    assign done      = (state == DONE);

endmodule

// File: tb/tb_lb_seq_player.sv
// Self-checking bench for lb_seq_player: slot-schedule reference model plus directed and random programs.
module tb_lb_seq_player;

    localparam int AW = 17, DW = 32, PROG_AW = 8, LEN_W = 11;
    localparam int SPACING = 3, READ_PIPE = 2, STALL_ADDR = 555;

    typedef struct packed { int cyc; logic [AW-1:0] addr; logic [DW-1:0] data; } bus_t;
    typedef struct packed { int cyc; logic [LEN_W-1:0] idx; logic [DW-1:0] data; logic last; } beat_t;

    logic               lb_clk = 1'b0, lb_rst_n = 1'b0, start = 1'b0;
    logic [AW-1:0]      rd_base = '0;
    logic [LEN_W-1:0]   rd_len = '0;
    logic [PROG_AW-1:0] prog_addr;
    logic               prog_valid = 1'b0;
    logic [AW-1:0]      prog_ca = '0;
    logic [DW-1:0]      prog_cd = '0;
    logic [AW-1:0]      lb_addr;
    logic [DW-1:0]      lb_data, lb_out, rd_data;
    logic [DW-1:0]      p1 = '0, p2 = '0;
    logic               lb_write, lb_read, rd_valid, rd_last, busy, done;
    logic [LEN_W-1:0]   rd_index;

    logic [AW-1:0] m_ca [256];
    logic [DW-1:0] m_cd [256];
    logic          m_v  [256];

    bus_t  obs_w[$], obs_r[$], exp_w[$], exp_r[$];
    beat_t obs_b[$], exp_b[$];
    int    obs_done[$];
    int    exp_done, cyc = 0, t0 = 0, rel;
    int    busy_first, busy_cnt, viol, back0;
    bit    mon_en = 1'b0, seen_nz;
    int    n_pass = 0, n_total = 0;

    lb_seq_player #(
        .AW(AW), .DW(DW), .PROG_AW(PROG_AW), .LEN_W(LEN_W),
        .SPACING(SPACING), .READ_PIPE(READ_PIPE), .STALL_ADDR(STALL_ADDR)
    ) dut (
        .lb_clk(lb_clk), .lb_rst_n(lb_rst_n), .start(start), .rd_base(rd_base), .rd_len(rd_len),
        .prog_addr(prog_addr), .prog_valid(prog_valid), .prog_ca(prog_ca), .prog_cd(prog_cd),
        .lb_addr(lb_addr), .lb_data(lb_data), .lb_write(lb_write), .lb_read(lb_read), .lb_out(lb_out),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_index(rd_index), .rd_last(rd_last),
        .busy(busy), .done(done)
    );

    always #5 lb_clk = ~lb_clk;
    always @(posedge lb_clk) cyc <= cyc + 1;

    // Synchronous program RAM and a two-cycle bus that answers addr ^ 0xA5.
    always @(posedge lb_clk) begin
        prog_valid <= m_v[prog_addr];
        prog_ca    <= m_ca[prog_addr];
        prog_cd    <= m_cd[prog_addr];
        p1         <= DW'(lb_addr) ^ 32'h0000_00A5;
        p2         <= p1;
    end
    assign lb_out = p2;

    always @(negedge lb_clk) begin
        if (mon_en) begin
            rel = cyc - t0;
            if (lb_write) obs_w.push_back(bus_t'{rel, lb_addr, lb_data});
            if (lb_read)  obs_r.push_back(bus_t'{rel, lb_addr, 32'h0});
            if (rd_valid) obs_b.push_back(beat_t'{rel, rd_index, rd_data, rd_last});
            if (done)     obs_done.push_back(rel);
            if (busy) begin
                if (busy_first < 0) busy_first = rel;
                busy_cnt++;
            end
            if (lb_write && lb_read) viol++;
            if (!lb_write && !lb_read && (lb_addr != '0 || lb_data != '0)) viol++;
            if (busy && prog_addr != '0) seen_nz = 1'b1;
            else if (busy && seen_nz) back0++;
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            m_v[i] = 1'b0; m_ca[i] = '0; m_cd[i] = '0;
        end
    endtask

    task automatic put(input int k, input int ca, input logic [DW-1:0] cd);
        m_v[k] = 1'b1; m_ca[k] = AW'(ca); m_cd[k] = cd;
    endtask

    // Reference: walk the list slot by slot in plain cycle arithmetic, relative to the start cycle.
    task automatic build_expected(input logic [AW-1:0] base, input int len);
        int s, k, r0;
        logic [AW-1:0] a;
        exp_w.delete(); exp_r.delete(); exp_b.delete();
        s = 1;
        k = 0;
        while (k < 256 && m_v[k]) begin
            if (m_ca[k] == AW'(STALL_ADDR)) s += SPACING + int'(m_cd[k]);
            else begin
                exp_w.push_back(bus_t'{s + 1, m_ca[k], m_cd[k]});
                s += SPACING;
            end
            k++;
        end
        r0 = s + SPACING;
        for (int i = 0; i < len; i++) begin
            a = base + AW'(i);
            exp_r.push_back(bus_t'{r0 + i, a, 32'h0});
            exp_b.push_back(beat_t'{r0 + i + READ_PIPE, LEN_W'(i), DW'(a) ^ 32'h0000_00A5, i == len - 1});
        end
        exp_done = (len == 0) ? r0 : r0 + len + READ_PIPE;
    endtask

    task automatic test_scenario(input string nm, input logic [AW-1:0] base, input int len);
        bit got = 1'b0;
        build_expected(base, len);
        obs_w.delete(); obs_r.delete(); obs_b.delete(); obs_done.delete();
        busy_first = -1; busy_cnt = 0; viol = 0; back0 = 0; seen_nz = 1'b0;
        @(negedge lb_clk);
        t0 = cyc; mon_en = 1'b1;
        start = 1'b1; rd_base = base; rd_len = LEN_W'(len);
        @(negedge lb_clk);
        start = 1'b0; rd_base = AW'($urandom); rd_len = LEN_W'($urandom);
        @(negedge lb_clk);
        start = 1'b1;
        @(negedge lb_clk);
        start = 1'b0;
        for (int i = 0; i < exp_done + 40; i++) begin
            @(negedge lb_clk);
            if (done) begin got = 1'b1; break; end
        end
        repeat (4) @(negedge lb_clk);
        mon_en = 1'b0;
        n_total++;
        if (got) n_pass++;
        else begin
            $display("FAIL %s timeout: done not seen, expected at t+%0d", nm, exp_done);
            lb_rst_n = 1'b0; @(negedge lb_clk); lb_rst_n = 1'b1;
        end
        n_total++;
        if (obs_w.size() == exp_w.size()) n_pass++;
        else $display("FAIL %s write_count: got %0d expected %0d", nm, obs_w.size(), exp_w.size());
        for (int i = 0; i < obs_w.size() && i < exp_w.size(); i++) begin
            n_total++;
            if (obs_w[i] === exp_w[i]) n_pass++;
            else $display("FAIL %s write[%0d]: got cyc=%0d a=%0h d=%0h expected cyc=%0d a=%0h d=%0h", nm, i,
                          obs_w[i].cyc, obs_w[i].addr, obs_w[i].data, exp_w[i].cyc, exp_w[i].addr, exp_w[i].data);
        end
        n_total++;
        if (obs_r.size() == exp_r.size()) n_pass++;
        else $display("FAIL %s read_count: got %0d expected %0d", nm, obs_r.size(), exp_r.size());
        for (int i = 0; i < obs_r.size() && i < exp_r.size(); i++) begin
            n_total++;
            if (obs_r[i] === exp_r[i]) n_pass++;
            else $display("FAIL %s read[%0d]: got cyc=%0d a=%0h expected cyc=%0d a=%0h", nm, i,
                          obs_r[i].cyc, obs_r[i].addr, exp_r[i].cyc, exp_r[i].addr);
        end
        n_total++;
        if (obs_b.size() == exp_b.size()) n_pass++;
        else $display("FAIL %s beat_count: got %0d expected %0d", nm, obs_b.size(), exp_b.size());
        for (int i = 0; i < obs_b.size() && i < exp_b.size(); i++) begin
            n_total++;
            if (obs_b[i] === exp_b[i]) n_pass++;
            else $display("FAIL %s beat[%0d]: got cyc=%0d idx=%0d d=%0h last=%0b expected cyc=%0d idx=%0d d=%0h last=%0b",
                          nm, i, obs_b[i].cyc, obs_b[i].idx, obs_b[i].data, obs_b[i].last,
                          exp_b[i].cyc, exp_b[i].idx, exp_b[i].data, exp_b[i].last);
        end
        n_total++;
        if (obs_done.size() == 1 && obs_done[0] == exp_done) n_pass++;
        else $display("FAIL %s done: got %0d pulses first at t+%0d expected one at t+%0d", nm, obs_done.size(),
                      (obs_done.size() > 0) ? obs_done[0] : -1, exp_done);
        n_total++;
        if (busy_first == 1 && busy_cnt == exp_done - 1) n_pass++;
        else $display("FAIL %s busy: got first=t+%0d count=%0d expected first=t+1 count=%0d", nm,
                      busy_first, busy_cnt, exp_done - 1);
        n_total++;
        if (viol == 0) n_pass++;
        else $display("FAIL %s bus_idle_exclusive: got %0d violations expected 0", nm, viol);
        n_total++;
        if (back0 == 0) n_pass++;
        else $display("FAIL %s prog_addr_rewind: got %0d cycles back at 0 expected 0", nm, back0);
    endtask

    task automatic test_reset();
        lb_rst_n = 1'b0;
        repeat (3) @(negedge lb_clk);
        n_total++;
        if ({prog_addr, lb_addr, lb_data, lb_write, lb_read, rd_data, rd_valid, rd_index, rd_last, busy, done} === '0)
            n_pass++;
        else $display("FAIL reset_outputs: got nonzero output, lb_addr=%0h busy=%0b expected all 0", lb_addr, busy);
        lb_rst_n = 1'b1;
        busy_cnt = 0;
        repeat (5) begin
            @(negedge lb_clk);
            if (busy || done || lb_write || lb_read || rd_valid) busy_cnt++;
        end
        n_total++;
        if (busy_cnt == 0) n_pass++;
        else $display("FAIL idle_quiet: got %0d active cycles expected 0", busy_cnt);
    endtask

    task automatic test_writes();
        clear_mem();
        put(0, 5, 32'h11); put(1, 7, 32'h22);
        test_scenario("writes", '0, 0);
        n_total++;
        if (obs_w.size() == 2 && obs_w[0].cyc == 2 && obs_w[1].cyc == 5 && obs_done.size() > 0 && obs_done[0] == 10)
            n_pass++;
        else $display("FAIL writes_timing: got %0d writes done=t+%0d expected writes at t+2,t+5 done at t+10",
                      obs_w.size(), (obs_done.size() > 0) ? obs_done[0] : -1);
    endtask

    task automatic test_stall();
        clear_mem();
        put(0, 5, 32'h1); put(1, STALL_ADDR, 32'd10); put(2, 6, 32'h2);
        test_scenario("stall", AW'(100), 1);
        n_total++;
        if (obs_w.size() == 2 && obs_w[1].cyc - obs_w[0].cyc == 16) n_pass++;
        else $display("FAIL stall_gap: got %0d writes gap=%0d expected gap 16", obs_w.size(),
                      (obs_w.size() == 2) ? obs_w[1].cyc - obs_w[0].cyc : -1);
    endtask

    task automatic test_read();
        int nlast = 0;
        clear_mem();
        test_scenario("read", AW'(81920), 4);
        foreach (obs_b[i]) if (obs_b[i].last) nlast++;
        n_total++;
        if (obs_r.size() == 4 && obs_r[0].addr == AW'(81920) && nlast == 1 && obs_b[3].last) n_pass++;
        else $display("FAIL read_burst: got %0d reads %0d last beats expected 4 reads from 81920, last on idx 3",
                      obs_r.size(), nlast);
    endtask

    task automatic test_wrap();
        clear_mem();
        put(0, 9, 32'hDEAD_BEEF);
        test_scenario("wrap", AW'(131070), 3);
        n_total++;
        if (obs_r.size() == 3 && obs_r[1].addr == AW'(131071) && obs_r[2].addr == '0) n_pass++;
        else $display("FAIL wrap_addr: got %0d reads last=%0h expected 131070,131071,0", obs_r.size(),
                      (obs_r.size() > 0) ? obs_r[obs_r.size()-1].addr : '1);
    endtask

    task automatic test_full();
        clear_mem();
        for (int i = 0; i < 256; i++) begin
            if (i == 40 || i == 255) put(i, STALL_ADDR, DW'(i % 7));
            else put(i, int'(AW'($urandom)) | 1024, $urandom);
        end
        test_scenario("full", AW'($urandom), 2);
        n_total++;
        if (obs_w.size() == 254) n_pass++;
        else $display("FAIL full_writes: got %0d expected 254", obs_w.size());
    endtask

    task automatic test_random();
        int n, len;
        for (int r = 0; r < 6; r++) begin
            clear_mem();
            n = $urandom_range(0, 12);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) put(i, STALL_ADDR, DW'($urandom_range(0, 12)));
                else put(i, int'($urandom_range(0, 131071)) & ~512, $urandom);
            end
            len = $urandom_range(0, 20);
            test_scenario($sformatf("random%0d", r), AW'($urandom), len);
        end
    endtask

    task automatic test_reset_mid();
        int cnt = 0;
        bit seen = 1'b0;
        clear_mem();
        @(negedge lb_clk);
        start = 1'b1; rd_base = AW'(81920); rd_len = LEN_W'(4);
        @(negedge lb_clk);
        start = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge lb_clk);
            if (lb_read) begin seen = 1'b1; break; end
        end
        n_total++;
        if (seen) n_pass++;
        else $display("FAIL mid_reset_reach_read: got no lb_read expected one within 50 cycles");
        @(negedge lb_clk);
        #1 lb_rst_n = 1'b0;
        #1;
        n_total++;
        if ({prog_addr, lb_addr, lb_data, lb_write, lb_read, rd_data, rd_valid, rd_index, rd_last, busy, done} === '0)
            n_pass++;
        else $display("FAIL mid_reset_async: got lb_read=%0b rd_valid=%0b busy=%0b expected all 0",
                      lb_read, rd_valid, busy);
        repeat (3) @(negedge lb_clk);
        lb_rst_n = 1'b1;
        repeat (12) begin
            @(negedge lb_clk);
            if (rd_valid || busy) cnt++;
        end
        n_total++;
        if (cnt == 0) n_pass++;
        else $display("FAIL mid_reset_no_beats: got %0d active cycles expected 0", cnt);
        test_scenario("rerun_read", AW'(81920), 4);
    endtask

    initial begin
        clear_mem();
        test_reset();
        test_writes();
        test_stall();
        test_read();
        test_wrap();
        test_full();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
